// File: rtl/ibuffer_pkg.sv
// Shared widths and entry layout for the instruction buffer.
// Entry packs {predicttarget, predicttaken, pc, instr}, MSB first.
package ibuffer_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_W       = 48;
  localparam int TARGET_W   = 32;
  localparam int IB_DEPTH   = 8;
  localparam int IB_ENTRY_W = TARGET_W + 1 + PC_W + INSTR_W;

  typedef struct packed {
    logic [TARGET_W-1:0] target;
    logic                taken;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  instr;
  } ib_entry_t;

endpackage

// File: rtl/ibuffer.sv
// Instruction buffer: circular FIFO between fetch and decode,
// first-word-fall-through head, one-cycle flush.
// Ports: clock, reset_n (sync, active-low), flush_valid,
//   ifu2ib_* push side, ib2ifu_instr_ready,
//   ibuffer_read_en pop, fifo_empty, ibuffer_*_out head, ibuffer_count.
module ibuffer
  import ibuffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_valid,
  input  logic                ifu2ib_instr_valid,
  input  logic [INSTR_W-1:0]  ifu2ib_instr,
  input  logic [PC_W-1:0]     ifu2ib_pc,
  input  logic                ifu2ib_predicttaken,
  input  logic [TARGET_W-1:0] ifu2ib_predicttarget,
  output logic                ib2ifu_instr_ready,
  input  logic                ibuffer_read_en,
  output logic                fifo_empty,
  output logic                ibuffer_instr_valid,
  output logic [INSTR_W-1:0]  ibuffer_inst_out,
  output logic [PC_W-1:0]     ibuffer_pc_out,
  output logic                ibuffer_predicttaken_out,
  output logic [TARGET_W-1:0] ibuffer_predicttarget_out,
  output logic [CNT_W-1:0]    ibuffer_count
);

  localparam int PTR_W = $clog2(DEPTH);

  ib_entry_t        mem [DEPTH];
  ib_entry_t        wr_entry;
  ib_entry_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;

  // Ready depends on registered count only; a same-cycle
  // pop never opens a slot for a same-cycle push.
  assign full               = (count == CNT_W'(DEPTH));
  assign fifo_empty         = (count == '0);
  assign ib2ifu_instr_ready = !full;
  assign ibuffer_count      = count;

  assign push = ifu2ib_instr_valid & !full & !flush_valid;
  assign pop  = ibuffer_read_en & !fifo_empty & !flush_valid;

  assign wr_entry = '{
    target: ifu2ib_predicttarget,
    taken:  ifu2ib_predicttaken,
    pc:     ifu2ib_pc,
    instr:  ifu2ib_instr
  };

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is never cleared; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (reset_n && push) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

  assign ibuffer_instr_valid       = !fifo_empty;
  assign ibuffer_inst_out          = fifo_empty ? '0 : head.instr;
  assign ibuffer_pc_out            = fifo_empty ? '0 : head.pc;
  assign ibuffer_predicttaken_out  = fifo_empty ? 1'b0 : head.taken;
  assign ibuffer_predicttarget_out = fifo_empty ? '0 : head.target;

endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer: queue model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_ibuffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] instr;
    logic [47:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush_valid;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [47:0] in_pc;
  logic        in_taken;
  logic [31:0] in_target;
  logic        ready;
  logic        read_en;
  logic        fifo_empty;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [47:0] out_pc;
  logic        out_taken;
  logic [31:0] out_target;
  logic [CNT_W-1:0] out_count;

  ent_t mq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  ibuffer #(.DEPTH(DEPTH)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .flush_valid               (flush_valid),
    .ifu2ib_instr_valid        (in_valid),
    .ifu2ib_instr              (in_instr),
    .ifu2ib_pc                 (in_pc),
    .ifu2ib_predicttaken       (in_taken),
    .ifu2ib_predicttarget      (in_target),
    .ib2ifu_instr_ready        (ready),
    .ibuffer_read_en           (read_en),
    .fifo_empty                (fifo_empty),
    .ibuffer_instr_valid       (out_valid),
    .ibuffer_inst_out          (out_instr),
    .ibuffer_pc_out            (out_pc),
    .ibuffer_predicttaken_out  (out_taken),
    .ibuffer_predicttarget_out (out_target),
    .ibuffer_count             (out_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    bit e;
    e = (mq.size() == 0);
    chk("m_empty", 64'(fifo_empty), 64'(e));
    chk("m_valid", 64'(out_valid), 64'(!e));
    chk("m_count", 64'(out_count), 64'(mq.size()));
    chk("m_ready", 64'(ready), 64'(mq.size() < DEPTH));
    if (e) begin
      chk("m_instr0", 64'(out_instr), 64'd0);
      chk("m_pc0", 64'(out_pc), 64'd0);
      chk("m_tk0", 64'(out_taken), 64'd0);
      chk("m_tg0", 64'(out_target), 64'd0);
    end else begin
      chk("m_instr", 64'(out_instr), 64'(mq[0].instr));
      chk("m_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("m_tk", 64'(out_taken), 64'(mq[0].taken));
      chk("m_tg", 64'(out_target), 64'(mq[0].target));
    end
  endtask

  // Model: reset/flush empty the queue; otherwise pop the head on a
  // read of a non-empty queue and append when the queue was not full.
  task automatic model_update();
    ent_t e;
    bit   was_full;
    bit   was_empty;
    if (!reset_n || flush_valid) begin
      mq.delete();
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (read_en && !was_empty) void'(mq.pop_front());
      if (in_valid && !was_full) begin
        e.instr  = in_instr;
        e.pc     = in_pc;
        e.taken  = in_taken;
        e.target = in_target;
        mq.push_back(e);
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic fl,
                      input logic v, input logic rd,
                      input logic [31:0] ins, input logic [47:0] pc,
                      input logic tk, input logic [31:0] tg);
    reset_n     = rst_n;
    flush_valid = fl;
    in_valid    = v;
    read_en     = rd;
    in_instr    = ins;
    in_pc       = pc;
    in_taken    = tk;
    in_target   = tg;
    @(posedge clock);
    model_update();
    @(negedge clock);
    model_cmp();
  endtask

  task automatic push(input logic [31:0] ins, input logic [47:0] pc);
    step(1, 0, 1, 0, ins, pc, 0, 0);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [47:0] BASE = 48'h8000_0000;

  initial begin
    reset_n = 0; flush_valid = 0; in_valid = 0; read_en = 0;
    in_instr = 0; in_pc = 0; in_taken = 0; in_target = 0;
    @(negedge clock);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h1, 48'h1, 0, 0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_count", 64'(out_count), 64'd0);

    push(32'h0000_0013, BASE);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_instr", 64'(out_instr), 64'h13);
    chk("first_pc", 64'(out_pc), 64'(BASE));
    chk("first_count", 64'(out_count), 64'd1);
    step(1, 0, 0, 1, 0, 0, 0, 0);

    for (int k = 0; k < 8; k++) push(32'(k), BASE + 48'(4 * k));
    chk("full_ready", 64'(ready), 64'd0);
    chk("full_count", 64'(out_count), 64'd8);
    push(32'hBAD, 48'h9000_0000);
    chk("ninth_count", 64'(out_count), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", 64'(out_pc), 64'(BASE + 48'(4 * k)));
      step(1, 0, 0, 1, 0, 0, 0, 0);
    end
    chk("drain_empty", 64'(fifo_empty), 64'd1);

    for (int k = 0; k < 8; k++) push(32'(k + 16), BASE + 48'(4 * k));
    step(1, 0, 1, 1, 32'hDEAD, 48'hDEAD, 0, 0);
    chk("fullpp_count", 64'(out_count), 64'd7);
    chk("fullpp_ready", 64'(ready), 64'd1);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 1, 0, 0, 0, 0);
    chk("fullpp_empty", 64'(fifo_empty), 64'd1);

    for (int j = 0; j < 3; j++) push(32'(j), BASE + 48'(4 * j));
    for (int i = 0; i < 20; i++) begin
      chk("steady_pc", 64'(out_pc), 64'(BASE + 48'(4 * i)));
      step(1, 0, 1, 1, 32'(i + 3), BASE + 48'(4 * (i + 3)), 0, 0);
      chk("steady_count", 64'(out_count), 64'd3);
    end
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) push(32'(k), BASE + 48'(4 * k));
    chk("preflush_count", 64'(out_count), 64'd5);
    step(1, 1, 1, 1, 32'hDEAD_BEEF, 48'hDEAD, 1, 32'hFFFF_FFFF);
    chk("flush_count", 64'(out_count), 64'd0);
    chk("flush_empty", 64'(fifo_empty), 64'd1);
    chk("flush_instr", 64'(out_instr), 64'd0);
    chk("flush_pc", 64'(out_pc), 64'd0);
    push(32'h0000_0093, 48'h8000_0100);
    chk("postflush_pc", 64'(out_pc), 64'h8000_0100);
    step(1, 0, 0, 1, 0, 0, 0, 0);

    step(1, 0, 1, 0, 32'h0000_006F, 48'h8000_0200, 1, 32'h8000_1000);
    chk("tag_taken", 64'(out_taken), 64'd1);
    chk("tag_target", 64'(out_target), 64'h8000_1000);
    chk("tag_pc", 64'(out_pc), 64'h8000_0200);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(199) != 0, $urandom_range(39) == 0,
           $urandom_range(3) != 0, $urandom_range(2) != 0,
           $urandom, {16'h0, $urandom}, 1'($urandom),
           $urandom);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
